// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction into ALU control, selects and bypasses
// operands, and registers the result into the EX slot under flush/stall control.
module alu_issue_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctrl,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [5:0]  ex_shamt,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_illegal
);
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b1111;
  localparam logic [3:0] ALU_BEQ = 4'b1110;

  // Register 0 reads as zero; otherwise the bypass value wins on an address match.
  function automatic logic [31:0] src_val(input logic [4:0] addr, input logic [31:0] rf_data,
                                          input logic fv, input logic [4:0] frd,
                                          input logic [31:0] fdata);
    logic [31:0] v;
    if (addr == 5'd0) begin
      v = 32'd0;
    end else if (FWD_EN && fv && (frd == addr)) begin
      v = fdata;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  logic [5:0]  op_s, funct_s;
  logic        rtype_s, use_imm_s, zext_s, shift_s;
  logic [3:0]  ctrl_s;
  logic        rw_s, mr_s, mw_s, br_s, ill_s;
  logic [4:0]  dest_s;
  logic [31:0] rs_val_s, rt_val_s, imm_s, data1_s, data2_s;

  logic        valid_d, valid_q;
  logic [3:0]  ctrl_d, ctrl_q;
  logic [31:0] data1_d, data1_q, data2_d, data2_q;
  logic [5:0]  shamt_d, shamt_q;
  logic [4:0]  rd_d, rd_q;
  logic        rw_d, rw_q, mr_d, mr_q, mw_d, mw_q, br_d, br_q, ill_d, ill_q;

  always_comb begin
    op_s      = instr[31:26];
    funct_s   = instr[5:0];
    rtype_s   = (op_s == 6'h00);
    ctrl_s    = ALU_ADD;
    use_imm_s = 1'b1;
    zext_s    = 1'b0;
    shift_s   = 1'b0;
    rw_s      = 1'b1;
    mr_s      = 1'b0;
    mw_s      = 1'b0;
    br_s      = 1'b0;
    ill_s     = 1'b0;
    if (rtype_s) begin
      use_imm_s = 1'b0;
      case (funct_s)
        6'h20, 6'h21: ctrl_s = ALU_ADD;
        6'h22, 6'h23: ctrl_s = ALU_SUB;
        6'h24:        ctrl_s = ALU_AND;
        6'h25:        ctrl_s = ALU_OR;
        6'h26:        ctrl_s = ALU_XOR;
        6'h2A:        ctrl_s = ALU_SLT;
        6'h00: begin ctrl_s = ALU_SLL; shift_s = 1'b1; end
        6'h02: begin ctrl_s = ALU_SRL; shift_s = 1'b1; end
        default: begin ill_s = 1'b1; rw_s = 1'b0; end
      endcase
    end else begin
      case (op_s)
        6'h08, 6'h09: ctrl_s = ALU_ADD;
        6'h0A:        ctrl_s = ALU_SLT;
        6'h0C: begin ctrl_s = ALU_AND; zext_s = 1'b1; end
        6'h0D: begin ctrl_s = ALU_OR;  zext_s = 1'b1; end
        6'h0E: begin ctrl_s = ALU_XOR; zext_s = 1'b1; end
        6'h0F: begin ctrl_s = ALU_LUI; zext_s = 1'b1; end
        6'h23:        mr_s = 1'b1;
        6'h2B: begin mw_s = 1'b1; rw_s = 1'b0; end
        6'h04: begin ctrl_s = ALU_BEQ; br_s = 1'b1; rw_s = 1'b0; use_imm_s = 1'b0; end
        default: begin ill_s = 1'b1; rw_s = 1'b0; end
      endcase
    end
    dest_s   = rtype_s ? instr[15:11] : instr[20:16];
    rs_val_s = src_val(instr[25:21], rs_data, fwd_valid, fwd_rd, fwd_data);
    rt_val_s = src_val(instr[20:16], rt_data, fwd_valid, fwd_rd, fwd_data);
    imm_s    = zext_s ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    // The ALU shifts data1, so shifts take rt there.
    data1_s  = shift_s ? rt_val_s : rs_val_s;
    data2_s  = use_imm_s ? imm_s : rt_val_s;
  end

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = 4'd0;
    data1_d = 32'd0;
    data2_d = 32'd0;
    shamt_d = 6'd0;
    rd_d    = 5'd0;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    br_d    = 1'b0;
    ill_d   = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data1_d = data1_q;
      data2_d = data2_q;
      shamt_d = shamt_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      mr_d    = mr_q;
      mw_d    = mw_q;
      br_d    = br_q;
      ill_d   = ill_q;
    end else if (in_valid) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_s;
      data1_d = data1_s;
      data2_d = data2_s;
      shamt_d = {1'b0, instr[10:6]};
      rd_d    = dest_s;
      rw_d    = rw_s && (dest_s != 5'd0);
      mr_d    = mr_s;
      mw_d    = mw_s;
      br_d    = br_s;
      ill_d   = ill_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= 4'd0;
      data1_q <= 32'd0;
      data2_q <= 32'd0;
      shamt_q <= 6'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      shamt_q <= shamt_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready     = ~stall;
  assign ex_valid     = valid_q;
  assign ex_alu_ctrl  = ctrl_q;
  assign ex_data1     = data1_q;
  assign ex_data2     = data2_q;
  assign ex_shamt     = shamt_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = rw_q;
  assign ex_mem_read  = mr_q;
  assign ex_mem_write = mw_q;
  assign ex_branch    = br_q;
  assign ex_illegal   = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed vector bench for alu_issue_stage: decode table plus reset/stall/flush sequences.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, fwd_valid, stall, flush;
  logic [31:0] instr, rs_data, rt_data, fwd_data;
  logic [4:0]  fwd_rd;
  logic        in_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_data1, ex_data2;
  logic [5:0]  ex_shamt;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .stall(stall), .flush(flush), .in_ready(in_ready),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_shamt(ex_shamt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fd;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  sh;
    logic [4:0]  rd;
    logic [4:0]  flags;  // {reg_write, mem_read, mem_write, branch, illegal}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [84:0] outs();
    return {ex_valid, ex_alu_ctrl, ex_data1, ex_data2, ex_shamt, ex_rd,
            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal};
  endfunction

  task automatic check(input string name, input logic [84:0] act, input logic [84:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = v;
    instr    = ins;
    rs_data  = a;
    rt_data  = b;
  endtask

  logic [84:0] held;
  logic [84:0] lw_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0; stall = 1'b0; flush = 1'b0;

    //                  instr                                    vld   rs            rt            fv    frd    fd             ctrl     d1            d2            sh     rd     flags
    vecs.push_back('{r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),     1'b1, 32'd5,        32'd7,        1'b0, 5'd0,  32'd0,         4'b0001, 32'd5,        32'd7,        6'd0,  5'd3,  5'b10000});
    vecs.push_back('{r_type(5'd0, 5'd2, 5'd4, 5'd3, 6'h00),     1'b1, 32'd0,        32'h0000000F, 1'b0, 5'd0,  32'd0,         4'b0000, 32'h0000000F, 32'h0000000F, 6'd3,  5'd4,  5'b10000});
    vecs.push_back('{i_type(6'h08, 5'd1, 5'd6, 16'hFFFF),       1'b1, 32'd10,       32'd0,        1'b0, 5'd0,  32'd0,         4'b0001, 32'd10,       32'hFFFFFFFF, 6'd31, 5'd6,  5'b10000});
    vecs.push_back('{i_type(6'h0D, 5'd1, 5'd7, 16'hFFFF),       1'b1, 32'd10,       32'd0,        1'b0, 5'd0,  32'd0,         4'b0101, 32'd10,       32'h0000FFFF, 6'd31, 5'd7,  5'b10000});
    vecs.push_back('{r_type(5'd1, 5'd0, 5'd5, 5'd0, 6'h20),     1'b1, 32'd9,        32'h0000DEAD, 1'b1, 5'd1,  32'h00001234,  4'b0001, 32'h00001234, 32'd0,        6'd0,  5'd5,  5'b10000});
    vecs.push_back('{r_type(5'd1, 5'd0, 5'd5, 5'd0, 6'h20),     1'b1, 32'd9,        32'h0000DEAD, 1'b1, 5'd0,  32'h00001234,  4'b0001, 32'd9,        32'd0,        6'd0,  5'd5,  5'b10000});
    vecs.push_back('{i_type(6'h2B, 5'd1, 5'd0, 16'h0008),       1'b1, 32'h00000100, 32'h00000055, 1'b0, 5'd0,  32'd0,         4'b0001, 32'h00000100, 32'd8,        6'd0,  5'd0,  5'b00100});
    vecs.push_back('{32'hFC000000,                               1'b1, 32'd3,        32'd4,        1'b0, 5'd0,  32'd0,         4'b0001, 32'd0,        32'd0,        6'd0,  5'd0,  5'b00001});
    vecs.push_back('{r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F),     1'b1, 32'd1,        32'd2,        1'b0, 5'd0,  32'd0,         4'b0001, 32'd1,        32'd2,        6'd0,  5'd3,  5'b00001});
    vecs.push_back('{r_type(5'd3, 5'd4, 5'd8, 5'd0, 6'h22),     1'b1, 32'd10,       32'd3,        1'b0, 5'd0,  32'd0,         4'b0010, 32'd10,       32'd3,        6'd0,  5'd8,  5'b10000});
    vecs.push_back('{r_type(5'd0, 5'd5, 5'd9, 5'd2, 6'h02),     1'b1, 32'd0,        32'h00000080, 1'b0, 5'd0,  32'd0,         4'b1111, 32'h00000080, 32'h00000080, 6'd2,  5'd9,  5'b10000});
    vecs.push_back('{i_type(6'h0A, 5'd1, 5'd10, 16'hFFFF),      1'b1, 32'd4,        32'd0,        1'b0, 5'd0,  32'd0,         4'b1010, 32'd4,        32'hFFFFFFFF, 6'd31, 5'd10, 5'b10000});
    vecs.push_back('{i_type(6'h0F, 5'd0, 5'd11, 16'h1234),      1'b1, 32'h0000FFFF, 32'd0,        1'b0, 5'd0,  32'd0,         4'b0111, 32'd0,        32'h00001234, 6'd8,  5'd11, 5'b10000});
    vecs.push_back('{i_type(6'h04, 5'd1, 5'd2, 16'h0010),       1'b1, 32'd6,        32'd6,        1'b0, 5'd0,  32'd0,         4'b1110, 32'd6,        32'd6,        6'd0,  5'd2,  5'b00010});
    vecs.push_back('{i_type(6'h23, 5'd1, 5'd12, 16'h0004),      1'b1, 32'h00002000, 32'd0,        1'b0, 5'd0,  32'd0,         4'b0001, 32'h00002000, 32'd4,        6'd0,  5'd12, 5'b11000});
    vecs.push_back('{r_type(5'd1, 5'd2, 5'd13, 5'd0, 6'h24),    1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 5'd0,  32'd0,         4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 6'd0,  5'd13, 5'b10000});
    vecs.push_back('{r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h20),     1'b1, 32'd1,        32'd2,        1'b0, 5'd0,  32'd0,         4'b0001, 32'd1,        32'd2,        6'd0,  5'd0,  5'b00000});
    vecs.push_back('{r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),     1'b0, 32'd5,        32'd7,        1'b0, 5'd0,  32'd0,         4'b0000, 32'd0,        32'd0,        6'd0,  5'd0,  5'b00000});

    #1;
    check("reset_state", outs(), 85'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].instr, vecs[i].rs, vecs[i].rt);
      fwd_valid = vecs[i].fv;
      fwd_rd    = vecs[i].frd;
      fwd_data  = vecs[i].fd;
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].vld, vecs[i].ctrl, vecs[i].d1, vecs[i].d2, vecs[i].sh, vecs[i].rd, vecs[i].flags});
    end
    fwd_valid = 1'b0;

    // lw in EX, then three stalled cycles with a different instruction on the inputs.
    @(negedge clk);
    drive(1'b1, i_type(6'h23, 5'd1, 5'd12, 16'h0004), 32'h00002000, 32'd0);
    lw_exp = {1'b1, 4'b0001, 32'h00002000, 32'd4, 6'd0, 5'd12, 5'b11000};
    step();
    check("lw_load", outs(), lw_exp);
    @(negedge clk);
    drive(1'b1, r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 32'd50, 32'd8);
    stall = 1'b1;
    #1;
    check1("in_ready_stall", in_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall_hold%0d", c), outs(), lw_exp);
    end
    // Flush beats stall.
    @(negedge clk);
    flush = 1'b1;
    step();
    check("flush_over_stall", outs(), 85'd0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check1("in_ready_run", in_ready, 1'b1);
    step();
    check("after_stall_load", outs(), {1'b1, 4'b0010, 32'd50, 32'd8, 6'd0, 5'd3, 5'b10000});

    // Asynchronous reset mid-stall with nonzero EX contents.
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 85'd0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    step();
    check1("post_reset_idle", ex_valid, 1'b0);
    step();
    check1("post_reset_idle2", ex_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
